// File: rtl/spongent_rng_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_rng_arbiter_if
//  Description : RNG chunk handshake plus requester grant/word bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spongent_rng_arbiter_if #(
    parameter int RATE     = 8,
    parameter int WORDSIZE = 32,
    parameter int NUM_REQ  = 4
);
    logic [RATE-1:0]     rng_data;
    logic                rng_valid;
    logic                rng_received;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  grant;
    logic [WORDSIZE-1:0] word_out;
    logic                health_fail;

    modport slave (
        input  rng_data, rng_valid, req,
        output rng_received, grant, word_out, health_fail
    );

    modport master (
        output rng_data, rng_valid, req,
        input  rng_received, grant, word_out, health_fail
    );
endinterface
`default_nettype wire

// File: rtl/spongent_rng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_rng_arbiter
//  Description : Packs RNG chunks into words, grants them round-robin and
//                locks out on a repetition-count health failure.
//  Revision    : 1.0 - initial release
// ============================================================================
module spongent_rng_arbiter #(
    parameter int RATE         = 8,
    parameter int WORDSIZE     = 32,
    parameter int NUM_REQ      = 4,
    parameter int REPEAT_LIMIT = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    spongent_rng_arbiter_if.slave    io_bus
);
    localparam int c_WORDS = WORDSIZE / RATE;
    localparam int c_CW    = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_RW    = $clog2(REPEAT_LIMIT + 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_READY = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic [WORDSIZE-1:0] r_shift_q,  w_shift_d;
    logic [c_CW-1:0]     r_cnt_q,    w_cnt_d;
    logic [c_PW-1:0]     r_ptr_q,    w_ptr_d;
    logic [RATE-1:0]     r_prev_q,   w_prev_d;
    logic [c_RW-1:0]     r_rep_q,    w_rep_d;
    logic                r_guard_q,  w_guard_d;
    logic [NUM_REQ-1:0]  r_grant_q,  w_grant_d;
    logic [WORDSIZE-1:0] r_word_q,   w_word_d;
    logic                r_health_q, w_health_d;

    logic [WORDSIZE-1:0] w_shift_cap;
    logic [c_RW-1:0]     w_rep_next;
    logic [c_PW-1:0]     w_winner;
    logic                w_capture;

    // First chunk of a word ends up in the MSBs.
    generate
        if (c_WORDS == 1) begin : g_single_chunk
            assign w_shift_cap = io_bus.rng_data;
        end else begin : g_multi_chunk
            assign w_shift_cap = {r_shift_q[WORDSIZE-RATE-1:0], io_bus.rng_data};
        end
    endgenerate

    // Circular search starting at the pointer.
    function automatic logic [c_PW-1:0] f_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [c_PW-1:0]    ptr);
        logic [c_PW-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx[c_PW-1:0]]) begin
                win   = idx[c_PW-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_capture  = (r_state_q == S_FILL) && io_bus.rng_valid && !r_guard_q;
    assign w_rep_next = (io_bus.rng_data == r_prev_q) ? (r_rep_q + c_RW'(1)) : c_RW'(1);
    assign w_winner   = f_pick(io_bus.req, r_ptr_q);

    always_comb begin
        w_state_d  = r_state_q;
        w_shift_d  = r_shift_q;
        w_cnt_d    = r_cnt_q;
        w_ptr_d    = r_ptr_q;
        w_prev_d   = r_prev_q;
        w_rep_d    = r_rep_q;
        w_guard_d  = 1'b0;
        w_grant_d  = '0;
        w_word_d   = r_word_q;
        w_health_d = r_health_q;
        case (r_state_q)
            S_FILL: begin
                if (w_capture) begin
                    w_guard_d = 1'b1;
                    w_shift_d = w_shift_cap;
                    w_prev_d  = io_bus.rng_data;
                    w_rep_d   = w_rep_next;
                    // A tripped health test outranks word completion.
                    if (w_rep_next == c_RW'(REPEAT_LIMIT)) begin
                        w_state_d  = S_ERROR;
                        w_health_d = 1'b1;
                        w_guard_d  = 1'b0;
                        w_shift_d  = '0;
                        w_cnt_d    = '0;
                    end else if (r_cnt_q == c_CW'(c_WORDS - 1)) begin
                        w_state_d = S_READY;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + c_CW'(1);
                    end
                end
            end
            S_READY: begin
                if (|io_bus.req) begin
                    w_grant_d = NUM_REQ'(1) << w_winner;
                    w_word_d  = r_shift_q;
                    w_ptr_d   = c_PW'((int'(w_winner) + 1) % NUM_REQ);
                    w_state_d = S_FILL;
                    w_cnt_d   = '0;
                end
            end
            S_ERROR: begin
                w_health_d = 1'b1;
            end
            default: begin
                w_state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_FILL;
            r_shift_q  <= '0;
            r_cnt_q    <= '0;
            r_ptr_q    <= '0;
            r_prev_q   <= '0;
            r_rep_q    <= '0;
            r_guard_q  <= 1'b0;
            r_grant_q  <= '0;
            r_word_q   <= '0;
            r_health_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_shift_q  <= w_shift_d;
            r_cnt_q    <= w_cnt_d;
            r_ptr_q    <= w_ptr_d;
            r_prev_q   <= w_prev_d;
            r_rep_q    <= w_rep_d;
            r_guard_q  <= w_guard_d;
            r_grant_q  <= w_grant_d;
            r_word_q   <= w_word_d;
            r_health_q <= w_health_d;
        end
    end

    // The guard flop doubles as the consumed-chunk pulse.
    assign io_bus.rng_received = r_guard_q;
    assign io_bus.grant        = r_grant_q;
    assign io_bus.word_out     = r_word_q;
    assign io_bus.health_fail  = r_health_q;
endmodule
`default_nettype wire

// File: tb/tb_spongent_rng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spongent_rng_arbiter
//  Description : Directed self-checking bench for spongent_rng_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spongent_rng_arbiter;
    logic clk;
    logic rst;

    spongent_rng_arbiter_if #(.RATE(8), .WORDSIZE(32), .NUM_REQ(4)) bus ();

    spongent_rng_arbiter #(
        .RATE(8), .WORDSIZE(32), .NUM_REQ(4), .REPEAT_LIMIT(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rcv_cnt  = 0;
    int grant_cnt = 0;
    int last_rcv = -1;
    int min_gap  = 1000;

    always @(negedge clk) begin
        cyc++;
        if (bus.rng_received === 1'b1) begin
            rcv_cnt++;
            if (last_rcv >= 0 && (cyc - last_rcv) < min_gap) min_gap = cyc - last_rcv;
            last_rcv = cyc;
        end
        if (bus.grant !== 4'b0000) grant_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rng_valid = 1'b0;
        bus.rng_data  = 8'h00;
        bus.req       = 4'b0000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rcv_cnt   = 0;
        grant_cnt = 0;
        last_rcv  = -1;
        min_gap   = 1000;
    endtask

    task automatic send_chunk(input logic [7:0] d);
        bit seen;
        seen = 1'b0;
        bus.rng_valid = 1'b1;
        bus.rng_data  = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.rng_received === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL send_chunk_%h: rng_received=0 required 1 within 20 cycles", d);
        end
        bus.rng_valid = 1'b0;
    endtask

    task automatic wait_grant(input logic [3:0] exp_g, input logic [31:0] exp_w, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.grant !== 4'b0000) found = 1'b1;
        end
        n_checks++;
        if (bus.grant !== exp_g) begin
            n_fail++;
            $display("FAIL %s_grant: got %b required %b", name, bus.grant, exp_g);
        end
        n_checks++;
        if (bus.word_out !== exp_w) begin
            n_fail++;
            $display("FAIL %s_word: got %h required %h", name, bus.word_out, exp_w);
        end
        tick();
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s_pulse: grant got %b required 0000 one cycle later", name, bus.grant);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b required 0000", bus.grant); end
        n_checks++;
        if (bus.word_out !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h required 0", bus.word_out); end
        n_checks++;
        if (bus.rng_received !== 1'b0) begin n_fail++; $display("FAIL reset_rcv: got %b required 0", bus.rng_received); end
        n_checks++;
        if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health: got %b required 0", bus.health_fail); end
    endtask

    task automatic test_single_word();
        do_reset();
        bus.req = 4'b0001;
        send_chunk(8'h11);
        send_chunk(8'h22);
        send_chunk(8'h33);
        send_chunk(8'h44);
        wait_grant(4'b0001, 32'h11223344, "single");
        n_checks++;
        if (rcv_cnt != 4) begin n_fail++; $display("FAIL single_rcv_count: got %0d required 4", rcv_cnt); end
        n_checks++;
        if (min_gap < 2) begin n_fail++; $display("FAIL single_rcv_gap: got %0d required >=2", min_gap); end
        n_checks++;
        if (grant_cnt != 1) begin n_fail++; $display("FAIL single_grant_count: got %0d required 1", grant_cnt); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 4'b1111;
        send_chunk(8'h01); send_chunk(8'h02); send_chunk(8'h03); send_chunk(8'h04);
        wait_grant(4'b0001, 32'h01020304, "rr0");
        send_chunk(8'h05); send_chunk(8'h06); send_chunk(8'h07); send_chunk(8'h08);
        wait_grant(4'b0010, 32'h05060708, "rr1");
        send_chunk(8'h09); send_chunk(8'h0A); send_chunk(8'h0B); send_chunk(8'h0C);
        wait_grant(4'b0100, 32'h090A0B0C, "rr2");
        bus.req = 4'b1001;
        send_chunk(8'h0D); send_chunk(8'h0E); send_chunk(8'h0F); send_chunk(8'h10);
        wait_grant(4'b1000, 32'h0D0E0F10, "rr3");
        send_chunk(8'h11); send_chunk(8'h12); send_chunk(8'h13); send_chunk(8'h14);
        wait_grant(4'b0001, 32'h11121314, "rr4");
    endtask

    task automatic test_hold_ready();
        int rcv_snap;
        do_reset();
        send_chunk(8'h21); send_chunk(8'h22); send_chunk(8'h23); send_chunk(8'h24);
        rcv_snap = rcv_cnt;
        bus.rng_valid = 1'b1;
        bus.rng_data  = 8'h55;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (rcv_cnt != rcv_snap) begin n_fail++; $display("FAIL hold_rcv: got %0d pulses required %0d", rcv_cnt, rcv_snap); end
        n_checks++;
        if (grant_cnt != 0) begin n_fail++; $display("FAIL hold_grant: got %0d grants required 0", grant_cnt); end
        bus.req = 4'b0100;
        tick();
        bus.rng_valid = 1'b0;
        n_checks++;
        if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL hold_late_grant: got %b required 0100", bus.grant); end
        n_checks++;
        if (bus.word_out !== 32'h21222324) begin n_fail++; $display("FAIL hold_word: got %h required 21222324", bus.word_out); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_health_fail();
        bit tripped;
        do_reset();
        bus.req = 4'b1111;
        send_chunk(8'hA5); send_chunk(8'hA5); send_chunk(8'hA5);
        n_checks++;
        if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_early: got %b required 0 after 3 repeats", bus.health_fail); end
        tripped = 1'b0;
        bus.rng_valid = 1'b1;
        bus.rng_data  = 8'hA5;
        for (int i = 0; i < 10 && !tripped; i++) begin
            tick();
            if (bus.health_fail === 1'b1) tripped = 1'b1;
        end
        n_checks++;
        if (!tripped) begin n_fail++; $display("FAIL health_trip: health_fail got 0 required 1 after 4th repeat"); end
        bus.rng_data = 8'h01;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (grant_cnt != 0) begin n_fail++; $display("FAIL health_lockout_grant: got %0d grants required 0", grant_cnt); end
        n_checks++;
        if (rcv_cnt != 3) begin n_fail++; $display("FAIL health_lockout_rcv: got %0d pulses required 3", rcv_cnt); end
        n_checks++;
        if (bus.health_fail !== 1'b1) begin n_fail++; $display("FAIL health_sticky: got %b required 1", bus.health_fail); end
        do_reset();
        n_checks++;
        if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_clear: got %b required 0", bus.health_fail); end
        bus.req = 4'b1111;
        send_chunk(8'h01); send_chunk(8'h02); send_chunk(8'h03); send_chunk(8'h04);
        wait_grant(4'b0001, 32'h01020304, "health_recover");
    endtask

    task automatic test_nonadjacent_repeats();
        do_reset();
        bus.req = 4'b0001;
        send_chunk(8'hA5); send_chunk(8'hA5); send_chunk(8'h3C); send_chunk(8'hA5);
        wait_grant(4'b0001, 32'hA5A53CA5, "nonadj0");
        send_chunk(8'hA5); send_chunk(8'hA5); send_chunk(8'h02); send_chunk(8'h03);
        wait_grant(4'b0001, 32'hA5A50203, "nonadj1");
        n_checks++;
        if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL nonadj_health: got %b required 0", bus.health_fail); end
    endtask

    task automatic test_reset_midfill();
        do_reset();
        bus.req = 4'b0001;
        send_chunk(8'h77);
        send_chunk(8'h88);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.word_out !== 32'h0) begin n_fail++; $display("FAIL midreset_word: got %h required 0", bus.word_out); end
        send_chunk(8'h0A);
        send_chunk(8'h0B);
        send_chunk(8'h0C);
        send_chunk(8'h0D);
        wait_grant(4'b0001, 32'h0A0B0C0D, "midreset");
    endtask

    initial begin
        rst = 1'b1;
        bus.rng_valid = 1'b0;
        bus.rng_data  = 8'h00;
        bus.req       = 4'b0000;
        test_reset();
        test_single_word();
        test_round_robin();
        test_hold_ready();
        test_health_fail();
        test_nonadjacent_repeats();
        test_reset_midfill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/spongent_rng_arbiter.md
Name: spongent_rng_arbiter

Overview:
- Round-robin distributor that shares one randomized_spongent RNG between NUM_REQ consumers.
- Pulls RATE-bit chunks from the RNG via its out/out_valid/out_received handshake and packs them into WORDSIZE-bit words.
- Grants each completed word to exactly one requester; a word is never reused.
- Runs a repetition-count health test on the raw chunks and locks out all grants on failure.

Parameters:
- RATE, 8, chunk width delivered by the RNG; must match the RNG's RATE.
- WORDSIZE, 32, delivered word width; integer multiple of RATE, at least RATE.
- NUM_REQ, 4, number of requesters, at least 1.
- REPEAT_LIMIT, 4, number of consecutive identical chunks that trips the health test, at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- rng_data  input  RATE  chunk from RNG out.
- rng_valid  input  1  RNG out_valid.
- rng_received  output  1  one-cycle pulse to RNG out_received; chunk consumed.
- req  input  NUM_REQ  per-requester request level.
- grant  output  NUM_REQ  one-hot, one-cycle pulse; word_out is valid for the addressed requester.
- word_out  output  WORDSIZE  delivered word, registered.
- health_fail  output  1  sticky health-test failure.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over all other events.
- Reset values:
  - grant=0, word_out=0, rng_received=0, health_fail=0.
  - Internal: state=FILL, chunk count=0, round-robin pointer=0, previous chunk=0, repeat count=0, guard=0.
- State FILL (assemble a word):
  - Capture occurs when rng_valid=1 and guard=0.
  - On capture: shift register <= {shift[WORDSIZE-RATE-1:0], rng_data} (first chunk ends in the MSBs); rng_received=1 next cycle; guard=1 for that same cycle.
  - The guard makes the block ignore rng_valid in the cycle rng_received is high. The producer must drop rng_valid within one cycle of seeing rng_received.
  - Result: at most one capture per two cycles; rng_valid held high continuously gives a capture every other cycle.
  - Health test, on every capture:
    - rng_data equal to the previous chunk: repeat count +1; otherwise repeat count=1.
    - The first chunk after reset sets the count to 1.
    - If the count reaches REPEAT_LIMIT: go to ERROR. This takes precedence over word completion.
  - Chunk count wraps at WORDSIZE/RATE. The capture of the last chunk moves the block to READY (unless ERROR).
- State READY (word complete):
  - No captures; rng_received stays 0; the RNG stalls.
  - Arbitrate when req!=0: the winner is the first set bit at or above the pointer, searching circularly (pointer, pointer+1, ..., wrapping to 0).
  - Next cycle: grant=onehot(winner) for one cycle, word_out=assembled word, pointer=(winner+1) mod NUM_REQ, state=FILL, chunk count=0.
  - req=0: remain in READY indefinitely, holding the word.
  - req is sampled only in READY. A request dropped before sampling is not served.
- word_out holds its value between grants. It changes only on a grant cycle.
- Latency:
  - Last-chunk capture edge -> READY.
  - First READY cycle with req!=0 -> grant visible at the following edge.
  - Minimum 2 cycles from last capture to grant.
- State ERROR:
  - health_fail=1; grant=0; rng_received=0.
  - The partially assembled word is discarded.
  - Exit only through rst.
- NUM_REQ=1: the pointer is constant 0; grant[0] pulses once per word while req[0]=1.
- Reset mid-FILL or mid-READY discards the buffered word. The first grant after reset requires a full fresh word.

Test Plan:
- NUM_REQ=4, req=0001, RNG supplies chunks 11,22,33,44 (hex) -> one grant=0001 pulse, word_out=32'h11223344; four rng_received pulses, spaced at least 2 cycles apart.
- req=1111 held, 3 words supplied -> grants 0001,0010,0100. Then req=1001 -> next grant 1000, then 0001.
- Word complete, req=0 for 20 cycles, rng_valid=1 throughout -> no rng_received, no grant. Raise req=0100 -> grant=0100 exactly 1 cycle later.
- Chunks A5,A5,A5,A5 (REPEAT_LIMIT=4) -> health_fail=1 after the 4th capture, no grant even with req=1111. rst -> health_fail=0; fresh data 01..04 -> word 32'h01020304 granted.
- Non-adjacent repeats A5,A5,3C,A5,A5 -> no failure.
- rst asserted after 2 of 4 chunks, then 4 new chunks 0A,0B,0C,0D -> word_out=32'h0A0B0C0D; the pre-reset chunks do not appear.
